// File: rtl/vga_capture_rx_if.sv
// vga_capture_rx_if: VGA input stream and qualified pixel stream of vga_capture_rx
// master: VGA source and pixel consumer (drives h_sync/v_sync/in_*, reads pix_*/status)
// slave:  the capture block (reads h_sync/v_sync/in_*, drives pix_*, frame_start, locked, err_count)
// VGA_CAPTURE_CRC_EN adds frame_crc[15:0] to the slave outputs.
interface vga_capture_rx_if;
    logic       h_sync;
    logic       v_sync;
    logic [3:0] in_r;
    logic [3:0] in_g;
    logic [3:0] in_b;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_count;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
`endif
    modport master (
        output h_sync, v_sync, in_r, in_g, in_b,
        input  pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, err_count
`ifdef VGA_CAPTURE_CRC_EN
        , input frame_crc
`endif
    );
    modport slave (
        input  h_sync, v_sync, in_r, in_g, in_b,
        output pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, err_count
`ifdef VGA_CAPTURE_CRC_EN
        , output frame_crc
`endif
    );
endinterface

// File: rtl/vga_capture_rx.sv
// vga_capture_rx: samples a VGA sync/RGB stream, checks timing, reports lock and emits active pixels
// Ports: clk (pixel clock), reset (async, active-low), bus (vga_capture_rx_if.slave:
// h_sync/v_sync/in_r/in_g/in_b in; pix_valid/pix_x/pix_y/pix_r/pix_g/pix_b/frame_start/locked/err_count out).
// VGA_CAPTURE_CRC_EN: adds frame_crc, a CRC-16-CCITT over every valid pixel of each locked frame.
module vga_capture_rx #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_VISIBLE   = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_VISIBLE   = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input logic             clk,
    input logic             reset,
    vga_capture_rx_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] H_ACT0 = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT1 = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [9:0]  V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_ACT1 = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    logic        hs1_q, vs1_q, hs_prev_q, vs_prev_q;
    logic [11:0] rgb1_q;
    logic [10:0] h_idx_q, h_idx_d;
    logic [9:0]  line_idx_q, line_idx_d;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d, err_q, err_d;
    logic        skip_q, skip_d, locked_q, locked_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        hs_edge, vs_edge, line_bad, frame_bad, active;

    always_comb begin
        hs_edge = hs_prev_q && !hs1_q;
        vs_edge = vs_prev_q && !vs1_q;
        h_idx_d = hs_edge ? 11'd0 : (&h_idx_q) ? h_idx_q : h_idx_q + 11'd1;
        line_idx_d = vs_edge ? 10'd0 : (hs_edge && !(&line_idx_q)) ? line_idx_q + 10'd1 : line_idx_q;
        // h_idx_q/line_idx_q still describe the sample just before the edge
        line_bad = state_q != SEARCH && hs_edge && !skip_q && h_idx_q + 11'd1 != H_TOT;
        frame_bad = state_q != SEARCH && vs_edge && {1'b0, line_idx_q} + 11'd1 != V_TOT;
        state_d = state_q;
        good_d = good_q;
        err_d = err_q;
        skip_d = skip_q && !hs_edge;
        if (state_q == SEARCH) begin
            if (vs_edge) begin
                state_d = MEASURE;
                good_d = 8'd0;
                skip_d = 1'b1;
            end
        end else if (line_bad || frame_bad) begin
            state_d = SEARCH;
            good_d = 8'd0;
            err_d = (&err_q) ? err_q : err_q + 8'd1;
        end else if (state_q == MEASURE && vs_edge) begin
            good_d = good_q + 8'd1;
            state_d = good_d >= LOCK_N ? LOCKED : MEASURE;
        end
        locked_d = state_d == LOCKED;
        active = h_idx_d >= H_ACT0 && h_idx_d < H_ACT1 && line_idx_d >= V_ACT0 && line_idx_d < V_ACT1;
        pix_valid_d = locked_q && active;
        pix_x_d = pix_valid_d ? 10'(h_idx_d - H_ACT0) : pix_x_q;
        pix_y_d = pix_valid_d ? line_idx_d - V_ACT0 : pix_y_q;
        pix_rgb_d = pix_valid_d ? rgb1_q : 12'd0;
        frame_start_d = pix_valid_d && h_idx_d == H_ACT0 && line_idx_d == V_ACT0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            rgb1_q        <= '0;
            h_idx_q       <= '0;
            line_idx_q    <= '0;
            state_q       <= SEARCH;
            good_q        <= '0;
            err_q         <= '0;
            skip_q        <= 1'b0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hs1_q         <= bus.h_sync;
            vs1_q         <= bus.v_sync;
            hs_prev_q     <= hs1_q;
            vs_prev_q     <= vs1_q;
            rgb1_q        <= {bus.in_r, bus.in_g, bus.in_b};
            h_idx_q       <= h_idx_d;
            line_idx_q    <= line_idx_d;
            state_q       <= state_d;
            good_q        <= good_d;
            err_q         <= err_d;
            skip_q        <= skip_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_r       = pix_rgb_q[11:8];
    assign bus.pix_g       = pix_rgb_q[7:4];
    assign bus.pix_b       = pix_rgb_q[3:0];
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.err_count   = err_q;

`ifdef VGA_CAPTURE_CRC_EN
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE - 1);

    logic [15:0] crc_q, crc_d, crc_next, frame_crc_q, frame_crc_d;
    logic        last_pix;

    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) r = {r[14:0], 1'b0} ^ (r[15] ^ d[i] ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    // accumulates over the registered output pixels; restarts whenever lock is lost
    always_comb begin
        crc_next = crc12(crc_q, pix_rgb_q);
        last_pix = pix_valid_q && pix_x_q == H_LAST && pix_y_q == V_LAST;
        crc_d = (!locked_q || last_pix) ? 16'hFFFF : pix_valid_q ? crc_next : crc_q;
        frame_crc_d = last_pix ? crc_next : frame_crc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign bus.frame_crc = frame_crc_q;
`endif
endmodule
